// File: rtl/cpu_defs_pkg.sv
// Shared encodings for the multicycle CPU control path: opcodes, FSM states,
// ALU operation, PC source and write-register select codes, plus the bundle
// of datapath control signals produced by the decoder.
package cpu_defs;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_XORI  = 6'b010011;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b100110;
  localparam logic [5:0] OP_SLT   = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] RD_RA = 2'b00;  // $31
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

  typedef struct packed {
    logic       pc_wre;
    logic       ir_wre;
    logic       ins_mem_rw;
    logic       reg_wre;
    logic [1:0] reg_dst;
    logic       wr_reg_d_src;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       ext_sel;
    logic [2:0] alu_op;
    logic       m_rd;
    logic       m_wr;
    logic       db_data_src;
    logic [1:0] pc_src;
  } ctrl_t;

  function automatic logic is_alu_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_XORI,
      OP_SLL, OP_SLTI, OP_SLT: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic logic is_branch_op(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLTZ);
  endfunction

  // Anything not recognised here retires in ID as a NOP.
  function automatic logic is_known_op(input logic [5:0] op);
    return is_alu_op(op) || is_branch_op(op) || (op == OP_SW) || (op == OP_LW) ||
           (op == OP_J) || (op == OP_JR) || (op == OP_JAL) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/mc_control_unit_decode.sv
// Purely combinational control decode.
//   state, op_code, zero, sign -> ctrl (all datapath control signals).
// Reset gating of the write enables is applied by the parent.
module mc_control_decode
  import cpu_defs::*;
(
  input  state_t     state,
  input  logic [5:0] op_code,
  input  logic       zero,
  input  logic       sign,
  output ctrl_t      ctrl
);

  logic taken;

  always_comb begin
    taken = 1'b0;
    case (op_code)
      OP_BEQ:  taken = zero;
      OP_BNE:  taken = ~zero;
      OP_BLTZ: taken = sign;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    ctrl              = '0;
    ctrl.ins_mem_rw   = 1'b1;
    ctrl.ext_sel      = 1'b1;
    ctrl.wr_reg_d_src = 1'b1;
    ctrl.reg_dst      = RD_RT;
    ctrl.alu_op       = ALU_ADD;
    ctrl.pc_src       = PC_NEXT;

    // Datapath selects depend only on the opcode.
    case (op_code)
      OP_ADD:   ctrl.reg_dst = RD_RD;
      OP_SUB:   begin ctrl.reg_dst = RD_RD; ctrl.alu_op = ALU_SUB; end
      OP_ADDIU: ctrl.alu_src_b = 1'b1;
      OP_AND:   begin ctrl.reg_dst = RD_RD; ctrl.alu_op = ALU_AND; end
      OP_ANDI:  begin ctrl.alu_src_b = 1'b1; ctrl.ext_sel = 1'b0; ctrl.alu_op = ALU_AND; end
      OP_ORI:   begin ctrl.alu_src_b = 1'b1; ctrl.ext_sel = 1'b0; ctrl.alu_op = ALU_OR;  end
      OP_XORI:  begin ctrl.alu_src_b = 1'b1; ctrl.ext_sel = 1'b0; ctrl.alu_op = ALU_XOR; end
      OP_SLL:   begin ctrl.reg_dst = RD_RD; ctrl.alu_src_a = 1'b1; ctrl.alu_op = ALU_SLL; end
      OP_SLTI:  begin ctrl.alu_src_b = 1'b1; ctrl.alu_op = ALU_SLT; end
      OP_SLT:   begin ctrl.reg_dst = RD_RD; ctrl.alu_op = ALU_SLT; end
      OP_SW, OP_LW: ctrl.alu_src_b = 1'b1;
      OP_BEQ, OP_BNE, OP_BLTZ: ctrl.alu_op = ALU_SUB;
      OP_JAL:   begin ctrl.reg_dst = RD_RA; ctrl.wr_reg_d_src = 1'b0; end
      default:  ;
    endcase

    // Enables and PC source depend on where we are in the instruction.
    case (state)
      S_IF: ctrl.ir_wre = 1'b1;
      S_ID: begin
        if (op_code == OP_J || op_code == OP_JAL) begin
          ctrl.pc_wre = 1'b1;
          ctrl.pc_src = PC_JUMP;
          ctrl.reg_wre = (op_code == OP_JAL);
        end else if (op_code == OP_JR) begin
          ctrl.pc_wre = 1'b1;
          ctrl.pc_src = PC_RS;
        end else if (!is_known_op(op_code)) begin
          ctrl.pc_wre = 1'b1;  // NOP retires here
        end
      end
      S_EXE_BR: begin
        ctrl.pc_wre = 1'b1;
        ctrl.pc_src = taken ? PC_BRANCH : PC_NEXT;
      end
      S_MEM: begin
        if (op_code == OP_SW) begin
          ctrl.m_wr   = 1'b1;
          ctrl.pc_wre = 1'b1;
        end
        if (op_code == OP_LW) begin
          ctrl.m_rd        = 1'b1;
          ctrl.db_data_src = 1'b1;
        end
      end
      S_WB_LD: begin
        ctrl.reg_wre = 1'b1;
        ctrl.pc_wre  = 1'b1;
        if (op_code == OP_LW) begin
          ctrl.m_rd        = 1'b1;
          ctrl.db_data_src = 1'b1;
        end
      end
      S_WB_AL: begin
        ctrl.reg_wre = 1'b1;
        ctrl.pc_wre  = 1'b1;
      end
      default: ;  // S_EXE_LS, S_EXE_AL: no writes
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle CPU control unit: IF/ID/EXE/MEM/WB state register, next-state
// logic, and reset gating of every write/read enable.
// Ports: CLK/RST (async active-high), opCode/zero/sign from the datapath,
// state for the board LEDs, and the full set of datapath controls.
module mc_control_unit
  import cpu_defs::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] opCode,
  input  logic       zero,
  input  logic       sign,
  output logic [2:0] state,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic [2:0] ALUOp,
  output logic       mRD,
  output logic       mWR,
  output logic       DBDataSrc,
  output logic [1:0] PCSrc
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (opCode == OP_HALT)                        state_d = S_ID;
        else if (is_branch_op(opCode))                state_d = S_EXE_BR;
        else if (opCode == OP_SW || opCode == OP_LW)  state_d = S_EXE_LS;
        else if (is_alu_op(opCode))                   state_d = S_EXE_AL;
        else                                          state_d = S_IF;  // j/jal/jr, NOP
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_WB_AL:  state_d = S_IF;
      S_EXE_BR: state_d = S_IF;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = (opCode == OP_LW) ? S_WB_LD : S_IF;
      S_WB_LD:  state_d = S_IF;
      default:  state_d = S_IF;
    endcase
  end

  mc_control_decode u_decode (
    .state   (state_q),
    .op_code (opCode),
    .zero    (zero),
    .sign    (sign),
    .ctrl    (ctrl)
  );

  assign state     = state_q;
  // Enables are masked while RST is held so an abandoned instruction
  // cannot write anything.
  assign PCWre     = ctrl.pc_wre  & ~RST;
  assign IRWre     = ctrl.ir_wre  & ~RST;
  assign RegWre    = ctrl.reg_wre & ~RST;
  assign mRD       = ctrl.m_rd    & ~RST;
  assign mWR       = ctrl.m_wr    & ~RST;
  assign InsMemRW  = 1'b1;
  assign RegDst    = ctrl.reg_dst;
  assign WrRegDSrc = ctrl.wr_reg_d_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ExtSel    = ctrl.ext_sel;
  assign ALUOp     = ctrl.alu_op;
  assign DBDataSrc = ctrl.db_data_src;
  assign PCSrc     = ctrl.pc_src;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: walks each instruction class through
// its state sequence and checks the decoded controls at every state.
module tb_mc_control_unit;

  logic       CLK, RST;
  logic [5:0] opCode;
  logic       zero, sign;
  logic [2:0] state;
  logic       PCWre, IRWre, InsMemRW, RegWre;
  logic [1:0] RegDst;
  logic       WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel;
  logic [2:0] ALUOp;
  logic       mRD, mWR, DBDataSrc;
  logic [1:0] PCSrc;

  int errors = 0;
  int checks = 0;

  mc_control_unit dut (
    .CLK(CLK), .RST(RST), .opCode(opCode), .zero(zero), .sign(sign),
    .state(state), .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW),
    .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp),
    .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .PCSrc(PCSrc)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    RST = 1'b1; opCode = 6'b000000; zero = 1'b0; sign = 1'b0;
    #12;
    chk("rst_state",    8'(state),    8'd0);
    chk("rst_irwre",    8'(IRWre),    8'd0);
    chk("rst_pcwre",    8'(PCWre),    8'd0);
    chk("insmemrw",     8'(InsMemRW), 8'd1);
    RST = 1'b0; #1;
    chk("if_irwre",     8'(IRWre),    8'd1);

    // add: IF ID EXE_AL WB_AL IF
    tick(); chk("add_id",      8'(state),  8'd1);
            chk("add_id_pcw",  8'(PCWre),  8'd0);
            chk("add_id_irw",  8'(IRWre),  8'd0);
    tick(); chk("add_exe",     8'(state),  8'd6);
            chk("add_exe_pcw", 8'(PCWre),  8'd0);
            chk("add_exe_rw",  8'(RegWre), 8'd0);
    tick(); chk("add_wb",      8'(state),  8'd7);
            chk("add_wb_pcw",  8'(PCWre),  8'd1);
            chk("add_wb_rw",   8'(RegWre), 8'd1);
            chk("add_wb_dst",  8'(RegDst), 8'd2);
            chk("add_wb_alu",  8'(ALUOp),  8'd0);
    tick(); chk("add_if",      8'(state),  8'd0);

    // reset mid-EXE_AL
    tick(); tick(); chk("mid_exe", 8'(state), 8'd6);
    #2; RST = 1'b1; #1;
    chk("mrst_state", 8'(state),  8'd0);
    chk("mrst_pcw",   8'(PCWre),  8'd0);
    chk("mrst_rw",    8'(RegWre), 8'd0);
    chk("mrst_mwr",   8'(mWR),    8'd0);
    chk("mrst_irw",   8'(IRWre),  8'd0);
    tick();
    chk("mrst_hold",  8'(state),  8'd0);
    chk("mrst_irw2",  8'(IRWre),  8'd0);
    RST = 1'b0; #1;
    chk("mrst_rel_irw", 8'(IRWre), 8'd1);

    // lw: IF ID EXE_LS MEM WB_LD IF
    opCode = 6'b110001;
    tick(); chk("lw_id",      8'(state),     8'd1);
    tick(); chk("lw_exe",     8'(state),     8'd2);
            chk("lw_exe_b",   8'(ALUSrcB),   8'd1);
            chk("lw_exe_mrd", 8'(mRD),       8'd0);
    tick(); chk("lw_mem",     8'(state),     8'd3);
            chk("lw_mem_mrd", 8'(mRD),       8'd1);
            chk("lw_mem_db",  8'(DBDataSrc), 8'd1);
            chk("lw_mem_pcw", 8'(PCWre),     8'd0);
            chk("lw_mem_mwr", 8'(mWR),       8'd0);
    tick(); chk("lw_wb",      8'(state),     8'd4);
            chk("lw_wb_mrd",  8'(mRD),       8'd1);
            chk("lw_wb_db",   8'(DBDataSrc), 8'd1);
            chk("lw_wb_rw",   8'(RegWre),    8'd1);
            chk("lw_wb_dst",  8'(RegDst),    8'd1);
            chk("lw_wb_pcw",  8'(PCWre),     8'd1);
    tick(); chk("lw_if",      8'(state),     8'd0);

    // sw: IF ID EXE_LS MEM IF
    opCode = 6'b110000;
    tick(); chk("sw_id",      8'(state), 8'd1);
    tick(); chk("sw_exe",     8'(state), 8'd2);
            chk("sw_exe_mwr", 8'(mWR),   8'd0);
    tick(); chk("sw_mem",     8'(state), 8'd3);
            chk("sw_mem_mwr", 8'(mWR),   8'd1);
            chk("sw_mem_pcw", 8'(PCWre), 8'd1);
            chk("sw_mem_mrd", 8'(mRD),   8'd0);
    tick(); chk("sw_if",      8'(state), 8'd0);

    // beq taken / not taken
    opCode = 6'b110100; zero = 1'b1;
    tick(); chk("beq_id",     8'(state), 8'd1);
    tick(); chk("beq_br",     8'(state), 8'd5);
            chk("beq_t_src",  8'(PCSrc), 8'd1);
            chk("beq_pcw",    8'(PCWre), 8'd1);
            chk("beq_alu",    8'(ALUOp), 8'd1);
    zero = 1'b0; #1;
            chk("beq_nt_src", 8'(PCSrc), 8'd0);
    tick(); chk("beq_if",     8'(state), 8'd0);

    // bltz taken
    opCode = 6'b110110; sign = 1'b1;
    tick(); tick(); chk("bltz_br",  8'(state), 8'd5);
                    chk("bltz_src", 8'(PCSrc), 8'd1);
    tick(); sign = 1'b0;

    // bne not taken
    opCode = 6'b110101; zero = 1'b1;
    tick(); tick(); chk("bne_br",  8'(state), 8'd5);
                    chk("bne_src", 8'(PCSrc), 8'd0);
    tick(); zero = 1'b0;

    // andi: zero-extend, AND, rt destination
    opCode = 6'b010001;
    tick(); chk("andi_ext", 8'(ExtSel),  8'd0);
            chk("andi_alu", 8'(ALUOp),   8'd4);
            chk("andi_b",   8'(ALUSrcB), 8'd1);
    tick(); tick(); chk("andi_dst", 8'(RegDst), 8'd1);
    tick(); chk("andi_if", 8'(state), 8'd0);

    // sll: shamt source, rd destination
    opCode = 6'b011000;
    tick(); chk("sll_a",   8'(ALUSrcA), 8'd1);
            chk("sll_alu", 8'(ALUOp),   8'd2);
            chk("sll_dst", 8'(RegDst),  8'd2);
    tick(); tick(); tick();

    // slti
    opCode = 6'b100110;
    tick(); chk("slti_alu", 8'(ALUOp),  8'd5);
            chk("slti_ext", 8'(ExtSel), 8'd1);
    tick(); tick(); tick();

    // jal retires in ID
    opCode = 6'b111010;
    tick(); chk("jal_id",   8'(state),     8'd1);
            chk("jal_pcw",  8'(PCWre),     8'd1);
            chk("jal_src",  8'(PCSrc),     8'd3);
            chk("jal_rw",   8'(RegWre),    8'd1);
            chk("jal_dst",  8'(RegDst),    8'd0);
            chk("jal_wrd",  8'(WrRegDSrc), 8'd0);
    tick(); chk("jal_if",   8'(state),     8'd0);

    // jr
    opCode = 6'b111001;
    tick(); chk("jr_src", 8'(PCSrc),  8'd2);
            chk("jr_pcw", 8'(PCWre),  8'd1);
            chk("jr_rw",  8'(RegWre), 8'd0);
    tick(); chk("jr_if",  8'(state),  8'd0);

    // undefined opcode: NOP in ID
    opCode = 6'b000111;
    tick(); chk("nop_id",  8'(state),  8'd1);
            chk("nop_pcw", 8'(PCWre),  8'd1);
            chk("nop_src", 8'(PCSrc),  8'd0);
            chk("nop_rw",  8'(RegWre), 8'd0);
    tick(); chk("nop_if",  8'(state),  8'd0);

    // halt holds ID until reset
    opCode = 6'b111111;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("halt_state", 8'(state), 8'd1);
      chk("halt_pcw",   8'(PCWre), 8'd0);
      tick();
    end
    RST = 1'b1; #1;
    chk("halt_rst", 8'(state), 8'd0);
    RST = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle control unit: sequences the CPU datapath (PC, instruction register, register file, ALU, data memory) through IF/ID/EXE/MEM/WB states, one instruction at a time.
- Sits inside the CPU core beside the datapath. Its 3-bit state drives the board state LEDs; its PCWre drives the PCWre LED.
- Clocked by the debounced CPU clock.

Parameters:
- None. All opcode, state, ALUOp and PCSrc encodings are fixed in the shared package.

Ports:
- CLK  in  1  debounced CPU clock, rising edge
- RST  in  1  asynchronous reset, active-high
- opCode  in  6  IR[31:26], stable after IF
- zero  in  1  ALU result == 0
- sign  in  1  ALU result bit 31
- state  out  3  current FSM state
- PCWre  out  1  PC write enable
- IRWre  out  1  instruction register load
- InsMemRW  out  1  instruction memory read (always 1)
- RegWre  out  1  register file write enable
- RegDst  out  2  write register select: 00 $31, 01 rt, 10 rd
- WrRegDSrc  out  1  write data select: 0 PC+4, 1 DB
- ALUSrcA  out  1  1 = shamt, 0 = rs
- ALUSrcB  out  1  1 = extended immediate, 0 = rt
- ExtSel  out  1  1 = sign-extend, 0 = zero-extend
- ALUOp  out  3  ALU operation code
- mRD  out  1  data memory read
- mWR  out  1  data memory write
- DBDataSrc  out  1  1 = memory data, 0 = ALU result
- PCSrc  out  2  next-PC select: 00 PC+4, 01 branch, 10 rs (jr), 11 jump target

Behaviour:
- Opcodes:
  - add 000000, sub 000001, addiu 000010
  - and 010000, andi 010001, ori 010010, xori 010011, sll 011000
  - slti 100110, slt 100111
  - sw 110000, lw 110001
  - beq 110100, bne 110101, bltz 110110
  - j 111000, jr 111001, jal 111010, halt 111111
- States: IF 000, ID 001, EXE_LS 010, MEM 011, WB_LD 100, EXE_BR 101, EXE_AL 110, WB_AL 111.
- Only the state register is sequential. It updates on the CLK rising edge. All other outputs are combinational decodes of (state, opCode, zero, sign).
- Transitions:
  - IF -> ID, always.
  - ID -> IF for j, jal, jr.
  - ID -> ID (self-loop) for halt, until RST.
  - ID -> EXE_BR for beq, bne, bltz.
  - ID -> EXE_LS for sw, lw.
  - ID -> EXE_AL for all ALU-type opcodes.
  - EXE_AL -> WB_AL -> IF.
  - EXE_BR -> IF.
  - EXE_LS -> MEM.
  - MEM -> IF for sw; MEM -> WB_LD for lw.
  - WB_LD -> IF.
  - Undefined opcode in ID -> IF, with PCWre=1 and PCSrc=00 (treated as NOP).
- IRWre: 1 only in IF.
- PCWre: 1 only in the final state of each instruction:
  - ID for j, jal, jr
  - EXE_BR
  - MEM for sw
  - WB_AL
  - WB_LD
  - Never for halt.
- PCSrc:
  - 11 for j/jal; 10 for jr.
  - In EXE_BR, 01 if taken, else 00. Taken: beq when zero=1, bne when zero=0, bltz when sign=1.
  - 00 in all other states.
- RegWre: 1 in WB_AL, in WB_LD, and in ID for jal only.
- RegDst:
  - 00 for jal
  - 10 for add, sub, and, slt, sll
  - 01 otherwise
- WrRegDSrc: 0 for jal only.
- ALUSrcA: 1 for sll only.
- ALUSrcB: 1 for addiu, andi, ori, xori, slti, sw, lw.
- ExtSel: 0 for andi, ori, xori; 1 otherwise.
- ALUOp:
  - 000 add: add, addiu, sw, lw
  - 001 sub: sub, beq, bne, bltz
  - 010 sll
  - 011 or: ori
  - 100 and: and, andi
  - 101 signed less-than: slt, slti
  - 110 xor: xori
- Memory controls:
  - mWR: 1 only in MEM for sw.
  - mRD: 1 in MEM and WB_LD for lw.
  - DBDataSrc: 1 in MEM and WB_LD for lw; 0 otherwise.
- Reset:
  - RST high forces state=IF immediately, without waiting for CLK.
  - While RST is high, PCWre, IRWre, RegWre, mWR and mRD are forced to 0.
  - Reset mid-instruction abandons the instruction with no further writes.
  - After RST deasserts, the first edge performs IF -> ID with IRWre=1.
- InsMemRW is tied to 1.

Decomposition:
- Package cpu_defs holds:
  - opcode localparams
  - state encodings
  - ALUOp, PCSrc and RegDst codes
- Sub-module mc_control_decode: purely combinational (state, opCode, zero, sign) -> control signals.
- The top holds the state register, the next-state logic and the reset gating.

Test Plan:
- RST=1 mid-EXE_AL -> state=000 at once; PCWre=RegWre=mWR=IRWre=0 while RST is held.
- add (000000) after reset -> states 000,001,110,111,000. PCWre=1 only in 111. RegWre=1, RegDst=10, ALUOp=000 in 111.
- lw (110001) -> states 000,001,010,011,100,000. mRD=1 and DBDataSrc=1 in 011/100. RegWre=1, RegDst=01 in 100.
- sw (110000) -> states 000,001,010,011,000. mWR=1 only in 011, together with PCWre=1.
- beq with zero=1 then with zero=0 -> PCSrc=01, then 00, in state 101. bltz with sign=1 -> PCSrc=01. bne with zero=1 -> PCSrc=00.
- jal (111010) -> ID has PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0. halt (111111) -> state holds 001 for 10 cycles with PCWre=0.
